spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI peripheral (slave) endpoint, counterpart of spi_master on the same SPI bus.
//  Oversamples spi_clk_i, spi_cs_n_i and spi_mosi_i in the clk_i domain.
//  Presents received bytes with a one-cycle valid pulse.
//  Shifts out bytes from a one-entry TX holding register on spi_miso_o, MSB first.
// PARAMETERS
//  SPI_MODE  0  CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]; legal values 0..3
//  SYNC_FF   2  synchronizer depth on spi_clk_i, spi_cs_n_i and spi_mosi_i; must be >= 2
// PORTS
//  clk_i            in   1  system clock; all logic is on the rising edge
//  reset_l_i        in   1  reset, asynchronous, active-low
//  tx_data_byte_i   in   8  byte to send on the next SPI byte slot
//  tx_data_valid_i  in   1  write strobe; accepted only when tx_ready_o = 1
//  tx_ready_o       out  1  TX holding register empty
//  rx_data_byte_o   out  8  last received byte; holds until the next byte completes
//  rx_data_valid_o  out  1  one clk_i pulse per completed byte
//  spi_clk_i        in   1  SPI clock from master
//  spi_cs_n_i       in   1  chip select, active-low
//  spi_mosi_i       in   1  master-out serial data
//  spi_miso_o       out  1  slave-out serial data
// BEHAVIOUR
//  - Reset values: tx_ready_o=0, rx_data_byte_o=8'h00, rx_data_valid_o=0.
//    spi_miso_o=0 without the macro, Z with it.
//  - tx_ready_o rises on the first clk_i edge after reset release.
//  - Timing requirements: SCLK half-period >= 4 clk_i. CS_n fall to first SCLK edge >= 4 clk_i.
//  - Edge detect: on the synchronized spi_clk. Leading edge = transition away from idle level CPOL.
//  - Sample and shift edges:
//      CPHA=0: sample MOSI on the leading edge, shift MISO on the trailing edge.
//      CPHA=1: shift MISO on the leading edge, sample MOSI on the trailing edge.
//  - FSM IDLE -> ACTIVE: on synchronized CS_n falling.
//      Bit counter is cleared.
//      Shift register loads the holding byte, or 8'h00 if holding is empty (underrun).
//      Holding register is freed.
//      CPHA=0: MSB drives MISO at this point.
//  - FSM ACTIVE -> IDLE: on synchronized CS_n rising.
//      A partial byte is discarded: no rx_data_valid_o, counter is cleared.
//      Unsent shift-register bits are dropped. The holding register is unaffected.
//  - Byte completion: 3-bit counter wraps 7 -> 0 on the 8th sample edge.
//      rx_data_byte_o is updated and rx_data_valid_o pulses on the next clk_i.
//  - Next byte in the same frame: the shift register reloads from holding (or 8'h00) at the point where
//    the following byte's MSB must appear.
//      CPHA=0: after the 8th sample edge.
//      CPHA=1: at the next leading edge.
//      The holding register is freed and tx_ready_o rises the following cycle.
//  - TX write handshake:
//      tx_data_valid_i && tx_ready_o: byte captured, tx_ready_o drops next cycle.
//      tx_data_valid_i && !tx_ready_o: ignored, holding register unchanged.
//  - Simultaneous write and byte-start load: the load sees holding as empty and sends 8'h00.
//      The written byte stays in holding for the next slot.
//  - spi_clk edges while CS_n is high are ignored.
//  - Asynchronous reset mid-frame: all state returns to reset values. No valid pulse is produced.
// CONFIGURATION
//  SPI_SLAVE_MISO_HIZ_EN
//   defined:   spi_miso_o = 1'bz whenever synchronized CS_n is high or in reset (shared-bus use).
//   undefined: spi_miso_o is always driven. It holds 0 while CS_n is high or in reset.
// TESTING
//  Bench: SCLK = clk_i/8, CS_n setup 6 clk_i.
//  Run 1-4 for every SPI_MODE 0..3; run 5-6 with SPI_MODE 0. Run the full set with and without the macro.
//  1) Preload TX 8'h3C. Master sends 8'hC1 in one frame
//       -> rx_data_byte_o = 8'hC1 with exactly one rx_data_valid_o pulse; MISO carries 8'h3C, MSB first.
//  2) Preload TX 8'hBE. Write 8'hEF once tx_ready_o re-rises. Master sends 8'h12,8'h34 in one frame
//       -> RX 8'h12 then 8'h34; MISO 8'hBE then 8'hEF.
//  3) No TX preload. Master sends 8'hA5
//       -> MISO sends 8'h00, RX 8'hA5, tx_ready_o stays 1.
//  4) CS_n raised after 5 bits of 8'hFF, then a full frame with 8'h81
//       -> no pulse for the partial byte; next RX = 8'h81 (counter was cleared).
//  5) tx_data_valid_i with 8'h55 while tx_ready_o = 0 (holding 8'h77)
//       -> 8'h55 ignored; next MISO byte = 8'h77.
//  6) Assert reset_l_i = 0 at bit 4 of a frame
//       -> outputs at reset values immediately. After release and a new frame of 8'h5A: RX 8'h5A.
//       -> With the macro: MISO = Z while CS_n is high.

Source files
------------

// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversampled SCLK/CS_n/MOSI, byte-wide RX strobe, one-entry TX holding register.
// Optional SPI_SLAVE_MISO_HIZ_EN: release MISO (1'bz) whenever synchronized CS_n is high or in reset.
module spi_slave #(
  parameter int unsigned SPI_MODE = 0,
  parameter int unsigned SYNC_FF  = 2
) (
  input  logic       clk_i,
  input  logic       reset_l_i,
  input  logic [7:0] tx_data_byte_i,
  input  logic       tx_data_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_byte_o,
  output logic       rx_data_valid_o,
  input  logic       spi_clk_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o
);

  localparam logic CPOL = SPI_MODE[1];
  localparam logic CPHA = SPI_MODE[0];

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [SYNC_FF-1:0] sclk_sync_r;
  logic [SYNC_FF-1:0] cs_sync_r;
  logic [SYNC_FF-1:0] mosi_sync_r;
  logic               sclk_prev_r;
  state_t             state_r;
  logic [2:0]         cnt_r;
  logic [7:0]         rx_shift_r;
  logic [7:0]         tx_shift_r;
  logic [7:0]         hold_r;
  logic               hold_full_r;
  logic               first_r;
  logic               tx_ready_r;
  logic [7:0]         rx_byte_r;
  logic               rx_valid_r;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_edge_s;
  logic lead_s;
  logic trail_s;
  logic frame_s;
  logic sample_s;
  logic shift_s;
  logic byte_done_s;
  logic cs_fall_s;
  logic reload_s;
  logic load_s;
  logic wr_s;
  logic hold_full_nxt_s;
  logic [7:0] next_tx_s;

  assign sclk_s = sclk_sync_r[SYNC_FF-1];
  assign cs_s   = cs_sync_r[SYNC_FF-1];
  assign mosi_s = mosi_sync_r[SYNC_FF-1];

  // MOSI shares the SCLK synchronizer depth so the sampled bit lines up with the detected edge
  assign sclk_edge_s = sclk_s ^ sclk_prev_r;
  assign lead_s      = sclk_edge_s & (sclk_s != CPOL);
  assign trail_s     = sclk_edge_s & (sclk_s == CPOL);
  assign frame_s     = (state_r == ACTIVE) & ~cs_s;
  assign sample_s    = frame_s & (CPHA ? trail_s : lead_s);
  assign shift_s     = frame_s & (CPHA ? lead_s : trail_s);
  assign byte_done_s = sample_s & (cnt_r == 3'd7);
  assign cs_fall_s   = (state_r == IDLE) & ~cs_s;

  // CPHA=1 defers the next-byte load to the leading edge that must present its MSB
  assign reload_s = CPHA ? (shift_s & (cnt_r == 3'd0) & ~first_r) : byte_done_s;
  assign load_s   = cs_fall_s | reload_s;

  assign next_tx_s       = hold_full_r ? hold_r : 8'h00;
  assign wr_s            = tx_data_valid_i & tx_ready_r;
  assign hold_full_nxt_s = wr_s | (hold_full_r & ~load_s);

  // Input synchronizers and SCLK edge history
  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      sclk_sync_r <= {SYNC_FF{CPOL}};
      cs_sync_r   <= {SYNC_FF{1'b1}};
      mosi_sync_r <= {SYNC_FF{1'b0}};
      sclk_prev_r <= CPOL;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_FF-2:0], spi_clk_i};
      cs_sync_r   <= {cs_sync_r[SYNC_FF-2:0], spi_cs_n_i};
      mosi_sync_r <= {mosi_sync_r[SYNC_FF-2:0], spi_mosi_i};
      sclk_prev_r <= sclk_s;
    end
  end

  // TX holding register and write handshake
  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      tx_ready_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        hold_r <= tx_data_byte_i;
      end else begin
        hold_r <= hold_r;
      end
      hold_full_r <= hold_full_nxt_s;
      tx_ready_r  <= ~hold_full_nxt_s;
    end
  end

  // Frame FSM with RX/TX shift registers and byte counter
  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      rx_shift_r <= 8'h00;
      tx_shift_r <= 8'h00;
      first_r    <= 1'b0;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 3'd0;
          if (!cs_s) begin
            state_r    <= ACTIVE;
            tx_shift_r <= next_tx_s;
            first_r    <= 1'b1;
          end else begin
            tx_shift_r <= 8'h00;
            first_r    <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            // partial byte and unsent TX bits are abandoned
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            tx_shift_r <= 8'h00;
            first_r    <= 1'b0;
          end else begin
            if (sample_s) begin
              rx_shift_r <= {rx_shift_r[6:0], mosi_s};
              cnt_r      <= cnt_r + 3'd1;
            end else begin
              cnt_r <= cnt_r;
            end
            if (byte_done_s) begin
              rx_byte_r  <= {rx_shift_r[6:0], mosi_s};
              rx_valid_r <= 1'b1;
            end else begin
              rx_byte_r <= rx_byte_r;
            end
            if (reload_s) begin
              tx_shift_r <= next_tx_s;
            end else if (shift_s && (cnt_r != 3'd0)) begin
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end else begin
              tx_shift_r <= tx_shift_r;
            end
            if (shift_s && (cnt_r == 3'd0)) begin
              first_r <= 1'b0;
            end else begin
              first_r <= first_r;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= 3'd0;
          tx_shift_r <= 8'h00;
          first_r    <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready_o      = tx_ready_r;
  assign rx_data_byte_o  = rx_byte_r;
  assign rx_data_valid_o = rx_valid_r;

`ifdef SPI_SLAVE_MISO_HIZ_EN
  assign spi_miso_o = cs_s ? 1'bz : tx_shift_r[7];
`else
  assign spi_miso_o = tx_shift_r[7];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one DUT per SPI mode, expected RX bytes queued at stimulus time.
module tb_spi_slave;

  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic [7:0] tx_byte  [NM];
  logic       tx_valid [NM];
  logic       tx_ready [NM];
  logic [7:0] rx_byte  [NM];
  logic       rx_valid [NM];
  logic       sclk     [NM];
  logic       cs_n     [NM];
  logic       mosi     [NM];
  wire        miso     [NM];

  int checks = 0;
  int errors = 0;
  int cur_mode = 0;
  logic [7:0] exp_rx_q [$];
  logic [7:0] exp_miso_q [$];

`ifdef SPI_SLAVE_MISO_HIZ_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    logic [7:0] exp_v;

    spi_slave #(.SPI_MODE(g), .SYNC_FF(2)) u_dut (
      .clk_i           (clk),
      .reset_l_i       (reset_l),
      .tx_data_byte_i  (tx_byte[g]),
      .tx_data_valid_i (tx_valid[g]),
      .tx_ready_o      (tx_ready[g]),
      .rx_data_byte_o  (rx_byte[g]),
      .rx_data_valid_o (rx_valid[g]),
      .spi_clk_i       (sclk[g]),
      .spi_cs_n_i      (cs_n[g]),
      .spi_mosi_i      (mosi[g]),
      .spi_miso_o      (miso[g])
    );

    // monitor: every valid pulse must match the head of the expected queue
    always @(negedge clk) begin
      if (rx_valid[g] === 1'b1) begin
        checks++;
        if (g != cur_mode || exp_rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected mode=%0d got=%02h", g, rx_byte[g]);
        end else begin
          exp_v = exp_rx_q.pop_front();
          if (rx_byte[g] !== exp_v) begin
            errors++;
            $display("FAIL rx_byte mode=%0d got=%02h exp=%02h", g, rx_byte[g], exp_v);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s mode=%0d got=%02h exp=%02h", name, cur_mode, got, exp);
    end
  endtask

  task automatic wait_ready(input int m);
    int n;
    n = 0;
    while (tx_ready[m] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", {7'd0, tx_ready[m]}, 8'h01);
  endtask

  task automatic wr(input int m, input logic [7:0] d);
    tx_byte[m]  = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_rx_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rx_pending", 8'(exp_rx_q.size()), 8'h00);
  endtask

  task automatic frame(input int m, input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                       input int last_bits, input bit keep_cs, input bit chk_miso);
    logic [1:0] md;
    logic [7:0] mo;
    logic [7:0] mi;
    logic [7:0] ev;
    int nb;
    md = m[1:0];
    cs_n[m] = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < nbytes; k++) begin
      mo = (k == 0) ? b0 : b1;
      nb = (k == nbytes - 1) ? last_bits : 8;
      mi = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
        if (!md[0]) mosi[m] = mo[i];
        repeat (4) @(negedge clk);
        if (!md[0]) mi[i] = miso[m];
        sclk[m] = ~md[1];
        if (md[0]) mosi[m] = mo[i];
        repeat (4) @(negedge clk);
        if (md[0]) mi[i] = miso[m];
        sclk[m] = md[1];
      end
      if (chk_miso && nb == 8) begin
        if (exp_miso_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_queue mode=%0d got=%02h exp=none", m, mi);
        end else begin
          ev = exp_miso_q.pop_front();
          chk("miso_byte", mi, ev);
        end
      end
    end
    if (!keep_cs) begin
      repeat (4) @(negedge clk);
      cs_n[m] = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    for (int m = 0; m < NM; m++) begin
      tx_byte[m]  = 8'h00;
      tx_valid[m] = 1'b0;
      cs_n[m]     = 1'b1;
      mosi[m]     = 1'b0;
      sclk[m]     = (m >= 2) ? 1'b1 : 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < NM; m++) begin
      cur_mode = m;
      chk("reset_tx_ready", {7'd0, tx_ready[m]}, 8'h00);
      chk("reset_rx_valid", {7'd0, rx_valid[m]}, 8'h00);
      chk("reset_rx_byte", rx_byte[m], 8'h00);
      chk("reset_miso", {7'd0, miso[m]}, {7'd0, MISO_IDLE});
    end
    reset_l = 1'b1;
    @(negedge clk);
    cur_mode = 0;
    chk("ready_after_reset", {7'd0, tx_ready[0]}, 8'h01);

    for (int m = 0; m < NM; m++) begin
      cur_mode = m;
      wait_ready(m);
      // 1) preloaded single byte
      wr(m, 8'h3C);
      chk("ready_drop", {7'd0, tx_ready[m]}, 8'h00);
      exp_rx_q.push_back(8'hC1);
      exp_miso_q.push_back(8'h3C);
      frame(m, 8'hC1, 8'h00, 1, 8, 1'b0, 1'b1);
      drain();
      // 2) two bytes, second TX byte written once holding frees up
      wait_ready(m);
      wr(m, 8'hBE);
      exp_rx_q.push_back(8'h12);
      exp_rx_q.push_back(8'h34);
      exp_miso_q.push_back(8'hBE);
      exp_miso_q.push_back(8'hEF);
      fork
        frame(m, 8'h12, 8'h34, 2, 8, 1'b0, 1'b1);
        begin
          @(negedge clk);
          wait_ready(m);
          wr(m, 8'hEF);
        end
      join
      drain();
      // 3) underrun sends zeros
      wait_ready(m);
      exp_rx_q.push_back(8'hA5);
      exp_miso_q.push_back(8'h00);
      frame(m, 8'hA5, 8'h00, 1, 8, 1'b0, 1'b1);
      drain();
      chk("ready_underrun", {7'd0, tx_ready[m]}, 8'h01);
      // 4) partial byte discarded, counter restarts
      frame(m, 8'hFF, 8'h00, 1, 5, 1'b0, 1'b0);
      exp_rx_q.push_back(8'h81);
      exp_miso_q.push_back(8'h00);
      frame(m, 8'h81, 8'h00, 1, 8, 1'b0, 1'b1);
      drain();
    end

    cur_mode = 0;
    // 5) write while full is ignored
    wait_ready(0);
    wr(0, 8'h77);
    chk("ready_full", {7'd0, tx_ready[0]}, 8'h00);
    wr(0, 8'h55);
    exp_rx_q.push_back(8'h99);
    exp_miso_q.push_back(8'h77);
    frame(0, 8'h99, 8'h00, 1, 8, 1'b0, 1'b1);
    drain();

    // 6) reset in the middle of a frame
    frame(0, 8'hF0, 8'h00, 1, 4, 1'b1, 1'b0);
    reset_l = 1'b0;
    #1;
    chk("midreset_tx_ready", {7'd0, tx_ready[0]}, 8'h00);
    chk("midreset_rx_valid", {7'd0, rx_valid[0]}, 8'h00);
    chk("midreset_rx_byte", rx_byte[0], 8'h00);
    chk("midreset_miso", {7'd0, miso[0]}, {7'd0, MISO_IDLE});
    @(negedge clk);
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    wait_ready(0);
    repeat (4) @(negedge clk);
    chk("idle_miso", {7'd0, miso[0]}, {7'd0, MISO_IDLE});
    exp_rx_q.push_back(8'h5A);
    exp_miso_q.push_back(8'h00);
    frame(0, 8'h5A, 8'h00, 1, 8, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
